// File: rtl/bg_tile_fetch_ctrl.sv
// Background tile fetch sequencer: turns raster counters into tile-map and tile-pixel BRAM
// reads and delivers one RGB444 pixel per clock, LAT clocks after the counters.
module bg_tile_fetch_ctrl #(
    parameter int unsigned H_VIS     = 640,
    parameter int unsigned V_VIS     = 480,
    parameter int unsigned TILE_LOG2 = 4,
    parameter int unsigned LAT       = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [9:0]  i_h_cnt,
    input  logic [9:0]  i_v_cnt,
    input  logic [9:0]  i_scroll_x_in,
    input  logic        i_scroll_load,
    input  logic [3:0]  i_scroll_step,
    output logic [10:0] o_map_addr,
    input  logic [5:0]  i_map_data,
    output logic [13:0] o_tile_addr,
    input  logic [11:0] i_tile_data,
    output logic [9:0]  o_scroll_x,
    output logic [11:0] o_pixel,
    output logic        o_pixel_valid
);

    localparam logic [10:0] HVis11 = 11'(H_VIS);
    localparam logic [9:0]  HVis10 = 10'(H_VIS);
    localparam logic [9:0]  VVis10 = 10'(V_VIS);

    typedef enum logic {StWaitFrame, StActive} state_t;

    state_t                r_state;
    logic [9:0]            r_scroll_x;
    logic [9:0]            r_pend;
    logic                  r_pend_valid;
    logic [10:0]           r_map_addr;
    logic [13:0]           r_tile_addr;
    logic [TILE_LOG2-1:0]  r_ex0, r_ey0, r_ex1, r_ey1;
    logic [LAT-1:0]        r_vis;
    logic [11:0]           r_pixel;
    logic                  r_pixel_valid;

    logic        w_boundary;
    logic [10:0] w_step_sum;
    logic [9:0]  w_step_wrap;
    logic [9:0]  w_load_val;
    logic [9:0]  w_scroll_new;
    logic [9:0]  w_scroll_eff;
    logic [10:0] w_ex_sum;
    logic [10:0] w_ex;
    logic [10:0] w_row;
    logic [10:0] w_map_addr;
    logic        w_active;
    logic        w_vis0;

    always_comb begin
        w_boundary   = (i_h_cnt == 10'd0) && (i_v_cnt == 10'd0);
        w_step_sum   = {1'b0, r_scroll_x} + {7'b0, i_scroll_step};
        w_step_wrap  = 10'((w_step_sum >= HVis11) ? (w_step_sum - HVis11) : w_step_sum);
        w_load_val   = (i_scroll_x_in >= HVis10) ? (i_scroll_x_in - HVis10) : i_scroll_x_in;
        w_scroll_new = r_pend_valid ? r_pend : w_step_wrap;
        // The boundary pixel itself already belongs to the new frame, so it sees the new offset.
        w_scroll_eff = w_boundary ? w_scroll_new : r_scroll_x;
        w_ex_sum     = {1'b0, i_h_cnt} + {1'b0, w_scroll_eff};
        w_ex         = (w_ex_sum >= HVis11) ? (w_ex_sum - HVis11) : w_ex_sum;
        w_row        = 11'(i_v_cnt >> TILE_LOG2);
        w_map_addr   = (w_row << 5) + (w_row << 3) + (w_ex >> TILE_LOG2);
        w_active     = (r_state == StActive) || w_boundary;
        w_vis0       = (i_h_cnt < HVis10) && (i_v_cnt < VVis10) && w_active;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= StWaitFrame;
            r_scroll_x    <= '0;
            r_pend        <= '0;
            r_pend_valid  <= 1'b0;
            r_map_addr    <= '0;
            r_tile_addr   <= '0;
            r_ex0         <= '0;
            r_ey0         <= '0;
            r_ex1         <= '0;
            r_ey1         <= '0;
            r_vis         <= '0;
            r_pixel       <= '0;
            r_pixel_valid <= 1'b0;
        end else begin
            if (w_boundary) begin
                r_scroll_x <= w_scroll_new;
                r_state    <= StActive;
            end

            // A load on the boundary cycle is queued for the following frame.
            if (i_scroll_load) begin
                r_pend       <= w_load_val;
                r_pend_valid <= 1'b1;
            end else if (w_boundary) begin
                r_pend_valid <= 1'b0;
            end

            r_map_addr    <= w_map_addr;
            r_ex0         <= w_ex[TILE_LOG2-1:0];
            r_ey0         <= i_v_cnt[TILE_LOG2-1:0];
            r_ex1         <= r_ex0;
            r_ey1         <= r_ey0;
            r_tile_addr   <= {i_map_data, r_ey1, r_ex1};
            r_vis         <= {r_vis[LAT-2:0], w_vis0};
            r_pixel       <= r_vis[LAT-1] ? i_tile_data : 12'h000;
            r_pixel_valid <= r_vis[LAT-1];
        end
    end

    assign o_map_addr    = r_map_addr;
    assign o_tile_addr   = r_tile_addr;
    assign o_scroll_x    = r_scroll_x;
    assign o_pixel       = r_pixel;
    assign o_pixel_valid = r_pixel_valid;

endmodule

// File: tb/tb_bg_tile_fetch_ctrl.sv
// Scoreboard bench for bg_tile_fetch_ctrl: a frame-level model predicts each visible pixel,
// its arrival edge, the scroll offset in use and the tile-map address.
module tb_bg_tile_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  h_cnt = '0;
    logic [9:0]  v_cnt = '0;
    logic [9:0]  scroll_x_in = '0;
    logic        scroll_load = 1'b0;
    logic [3:0]  scroll_step = '0;
    logic [10:0] map_addr;
    logic [5:0]  map_data;
    logic [13:0] tile_addr;
    logic [11:0] tile_data;
    logic [9:0]  scroll_x;
    logic [11:0] pixel;
    logic        pixel_valid;

    bg_tile_fetch_ctrl dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_h_cnt       (h_cnt),
        .i_v_cnt       (v_cnt),
        .i_scroll_x_in (scroll_x_in),
        .i_scroll_load (scroll_load),
        .i_scroll_step (scroll_step),
        .o_map_addr    (map_addr),
        .i_map_data    (map_data),
        .o_tile_addr   (tile_addr),
        .i_tile_data   (tile_data),
        .o_scroll_x    (scroll_x),
        .o_pixel       (pixel),
        .o_pixel_valid (pixel_valid)
    );

    always #5 clk = ~clk;

    logic [5:0]  map_mem  [2048];
    logic [11:0] tile_mem [16384];

    always @(posedge clk) begin
        map_data  <= map_mem[map_addr];
        tile_data <= tile_mem[tile_addr];
    end

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    typedef struct {
        int          t;
        logic [11:0] pix;
    } exp_t;
    exp_t q[$];

    // Frame-level reference state, describing the DUT after the upcoming edge.
    bit m_active   = 0;
    int m_scroll   = 0;
    int m_pend     = 0;
    bit m_pend_v   = 0;
    bit exp_map_ck = 0;
    int exp_map    = 0;
    bit exp_rst    = 0;
    int g_step     = 0;
    bit mon_en     = 0;
    bit done       = 0;
    int n_chk      = 0;
    int n_err      = 0;

    function automatic logic [11:0] model_pix(int h, int v, int s);
        int ex;
        int idx;
        ex  = (h + s) % 640;
        idx = int'(map_mem[(v / 16) * 40 + ex / 16]);
        return tile_mem[idx * 256 + (v % 16) * 16 + ex % 16];
    endfunction

    task automatic drive(input int h, input int v, input bit ld, input int x, input bit r);
        int ex;
        @(negedge clk);
        h_cnt       = 10'(h);
        v_cnt       = 10'(v);
        scroll_load = ld;
        scroll_x_in = 10'(x);
        scroll_step = 4'(g_step);
        rst         = r;
        if (r) begin
            m_active = 0;
            m_scroll = 0;
            m_pend   = 0;
            m_pend_v = 0;
            while (q.size() > 0 && q[q.size() - 1].t >= edge_cnt + 1) void'(q.pop_back());
            exp_map_ck = 0;
            exp_rst    = 1;
        end else begin
            if (h == 0 && v == 0) begin
                if (m_pend_v) begin
                    m_scroll = m_pend;
                    m_pend_v = 0;
                end else begin
                    m_scroll = (m_scroll + g_step) % 640;
                end
                m_active = 1;
            end
            if (ld) begin
                m_pend   = (x >= 640) ? x - 640 : x;
                m_pend_v = 1;
            end
            ex = (h + m_scroll) % 640;
            if (h < 640 && v < 480 && m_active)
                q.push_back('{t: edge_cnt + 5, pix: model_pix(h, v, m_scroll)});
            exp_map_ck = (h < 640 && v < 480);
            exp_map    = (v / 16) * 40 + ex / 16;
            exp_rst    = 0;
        end
    endtask

    task automatic run_line(input int v, input int h0, input int n);
        for (int i = 0; i < n; i++) drive(h0 + i, v, 0, 0, 0);
    endtask

    // Monitor: samples 1 time unit after each active edge.
    always @(posedge clk) begin
        #1;
        if (mon_en) begin
            while (q.size() > 0 && q[0].t < edge_cnt) begin
                n_chk++;
                n_err++;
                $display("FAIL pixel_missing edge=%0d expected pixel %h never presented",
                         q[0].t, q[0].pix);
                void'(q.pop_front());
            end
            n_chk++;
            if (q.size() > 0 && q[0].t == edge_cnt) begin
                if (pixel_valid !== 1'b1 || pixel !== q[0].pix) begin
                    n_err++;
                    $display("FAIL pixel edge=%0d got valid=%b pix=%h want valid=1 pix=%h",
                             edge_cnt, pixel_valid, pixel, q[0].pix);
                end
                void'(q.pop_front());
            end else if (pixel_valid !== 1'b0 || pixel !== 12'h000) begin
                n_err++;
                $display("FAIL blank edge=%0d got valid=%b pix=%h want valid=0 pix=000",
                         edge_cnt, pixel_valid, pixel);
            end
            n_chk++;
            if (scroll_x !== 10'(m_scroll)) begin
                n_err++;
                $display("FAIL scroll_x edge=%0d got %0d want %0d", edge_cnt, scroll_x, m_scroll);
            end
            if (exp_map_ck) begin
                n_chk++;
                if (map_addr !== 11'(exp_map)) begin
                    n_err++;
                    $display("FAIL map_addr edge=%0d got %0d want %0d",
                             edge_cnt, map_addr, exp_map);
                end
            end
            if (exp_rst) begin
                n_chk++;
                if (map_addr !== 11'd0 || tile_addr !== 14'd0) begin
                    n_err++;
                    $display("FAIL reset_addr edge=%0d got map=%0d tile=%0d want 0 0",
                             edge_cnt, map_addr, tile_addr);
                end
            end
        end
        if (done) begin
            n_chk++;
            if (q.size() != 0) begin
                n_err++;
                $display("FAIL drain got %0d pixels outstanding want 0", q.size());
            end
            $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
            $finish;
        end
    end

    initial begin
        int  rnd;
        bit  ld;
        bit  rr;
        int  x;
        for (int i = 0; i < 2048; i++) map_mem[i] = 6'($urandom);
        for (int i = 0; i < 16384; i++) tile_mem[i] = 12'($urandom);
        map_mem[0]              = 6'd5;
        tile_mem[5 * 256 + 0]   = 12'hF00;
        tile_mem[5 * 256 + 3]   = 12'h0F0;

        // Reset, then release mid-frame: nothing valid until (0,0).
        drive(0, 100, 0, 0, 1);
        mon_en = 1;
        drive(0, 100, 0, 0, 1);
        run_line(100, 0, 20);
        run_line(0, 0, 20);

        // Two loads mid-frame; the later one wins at the boundary.
        drive(100, 5, 1, 630, 0);
        run_line(5, 101, 4);
        drive(105, 5, 1, 20, 0);
        run_line(5, 106, 4);
        run_line(0, 0, 8);

        // Auto-step wraps 636 + 8 to 4, then ten more frames.
        drive(200, 9, 1, 636, 0);
        run_line(0, 0, 4);
        g_step = 8;
        for (int f = 0; f < 11; f++) run_line(0, 0, 4);
        g_step = 0;

        // Last visible column and first blank column on line 17.
        drive(300, 17, 1, 5, 0);
        run_line(0, 0, 4);
        run_line(17, 636, 8);
        drive(1020, 300, 1, 1000, 0);
        run_line(0, 0, 6);

        // Randomised raster positions, loads, steps and occasional reset.
        for (int i = 0; i < 3000; i++) begin
            rnd = int'($urandom_range(0, 999));
            rr  = (rnd < 3);
            ld  = ($urandom_range(0, 99) < 5);
            x   = int'($urandom_range(0, 1023));
            if ($urandom_range(0, 199) == 0) g_step = int'($urandom_range(0, 15));
            if ($urandom_range(0, 49) == 0) drive(0, 0, ld, x, rr);
            else drive(int'($urandom_range(0, 799)), int'($urandom_range(0, 524)), ld, x, rr);
        end

        // Reset while valid pixels are in flight, then wait for the next frame.
        g_step = 3;
        run_line(0, 0, 10);
        run_line(2, 0, 10);
        drive(10, 2, 0, 0, 1);
        run_line(3, 0, 10);
        run_line(0, 0, 10);

        for (int i = 0; i < 8; i++) drive(700, 500, 0, 0, 0);
        done = 1;
    end

endmodule

// File: doc/bg_tile_fetch_ctrl.md
Name: bg_tile_fetch_ctrl

Overview:
- Sequences reads from the background tile-map BRAM and the tile-pixel BRAM so the background layer gets one 12-bit RGB pixel per clock for the current raster position.
- Owns the horizontal scroll state. Scroll updates take effect only at frame boundaries, so there is no mid-frame tearing.
- Sits between the VGA counters and the two background memories; its pixel output feeds the layer mixer.

Parameters:
- H_VIS, 640, visible width in pixels; also the scroll modulus.
- V_VIS, 480, visible height in lines.
- TILE_LOG2, 4, tile edge is 2^TILE_LOG2 pixels (16).
- MAP_W, 40, tiles per map row (H_VIS >> TILE_LOG2).
- LAT, 4, fixed latency in clocks from h_cnt/v_cnt to pixel.

Ports:
- clk  in  1  pixel clock; h_cnt advances once per clk.
- rst  in  1  synchronous reset, active-high.
- h_cnt  in  10  horizontal raster counter (0..799).
- v_cnt  in  10  vertical raster counter (0..524).
- scroll_x_in  in  10  new scroll offset, 0..H_VIS-1.
- scroll_load  in  1  one-cycle strobe; captures scroll_x_in as the pending offset.
- scroll_step  in  4  automatic per-frame scroll increment (0 = static).
- map_addr  out  11  tile-map BRAM address.
- map_data  in  6  tile index; 1-cycle registered read latency.
- tile_addr  out  14  tile-pixel BRAM address {tile_idx, ty[3:0], tx[3:0]}.
- tile_data  in  12  RGB444 colour; 1-cycle registered read latency.
- scroll_x  out  10  offset currently in use for this frame.
- pixel  out  12  background colour, aligned LAT clocks after its counters.
- pixel_valid  out  1  high when pixel belongs to the visible area.

Behaviour:
- Reset (rst=1 at a clk edge):
  - Outputs: map_addr=0, tile_addr=0, scroll_x=0, pixel=12'h000, pixel_valid=0.
  - Internals: pending-load flag cleared, all pipeline valid bits cleared, FSM=WAIT_FRAME.
  - Reset mid-line or mid-frame discards every in-flight pipeline stage.
- FSM:
  - WAIT_FRAME: pixel_valid forced 0. Goes to ACTIVE on the frame-boundary condition (h_cnt==0 && v_cnt==0), so the first output line is always a full line 0.
  - ACTIVE: remains there until rst.
- Frame-boundary update: when h_cnt==0 && v_cnt==0, in either state:
  - If a load is pending: scroll_x <= pending value, pending flag cleared.
  - Otherwise: scroll_x <= (scroll_x + scroll_step) mod H_VIS. Wrap by conditional subtract; e.g. 636+8 gives 4.
- scroll_load handling:
  - Any cycle: pending <= scroll_x_in, flag set. A later load before the boundary overwrites the earlier one.
  - Load coinciding with the boundary cycle: the old pending value (or the step, if none was pending) is applied this frame. The new value becomes pending for the next frame.
  - scroll_x_in >= H_VIS: reduced by a single subtract of H_VIS at capture.
- Pipeline (edges k..k+4 for counters sampled at edge k):
  - Stage 0 (edge k): ex = (h_cnt + scroll_x) mod H_VIS; ey = v_cnt. map_addr <= (ey>>4)*MAP_W + (ex>>4), computed as (row<<5)+(row<<3). ex[3:0], ey[3:0] and vis0 = (h_cnt<H_VIS && v_cnt<V_VIS && ACTIVE) are registered.
  - Edge k+1: the BRAM presents map_data; the stage-0 side fields are delayed one stage.
  - Edge k+2: tile_addr <= {map_data, ey[3:0], ex[3:0]}.
  - Edge k+3: the BRAM presents tile_data.
  - Edge k+4: pixel <= vis ? tile_data : 12'h000; pixel_valid <= vis.
- Addresses are still issued during blanking; the data is discarded. map_addr never exceeds 1199 for v_cnt<480, and is don't-care outside the visible region.
- scroll_x changes only at the boundary edge, so every pixel of a frame uses one offset.

Test Plan:
- Reset, then rst released at v_cnt=100 -> pixel_valid stays 0 until the counters wrap to (0,0). pixel_valid first rises 4 clocks after (0,0) is presented.
- scroll_x=0, map entry 0 = 5, tile ROM addr {5,0,0} = 12'hF00 -> pixel=12'hF00 at the 4th edge after h=0,v=0. Addr {5,0,3} = 12'h0F0 appears for h=3 three clocks later.
- scroll_load with 630 mid-frame, then a second load with 20 -> scroll_x stays unchanged until the next (0,0), then becomes 20. h=0 fetches map_addr=1 (ex=20).
- scroll_step=8, scroll_x=636 -> after the boundary scroll_x=4. Ten frames later it reads 84.
- Line at v=17, h=639, scroll_x=5 -> ex=4, map_addr=40+0=40. h=640 gives pixel_valid=0 and pixel=0 four clocks later.
- rst asserted for one cycle while pixel_valid=1 -> the next edge gives pixel=0, pixel_valid=0, scroll_x=0, and FSM waits for the next (0,0).
